// File: rtl/lmsm_sequencer_if.sv
// Bus bundle for the LM/SM sequencer: request, data-memory and register-file ports.
interface lmsm_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREGS  = 8
);
    localparam int IW = $clog2(NREGS);

    logic              start;
    logic              is_store;
    logic [ADDR_W-1:0] base_addr;
    logic [NREGS-1:0]  reg_mask;
    logic              stall;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;
    logic [IW-1:0]     reg_rd_addr;
    logic [DATA_W-1:0] reg_rd_data;
    logic              reg_wr_en;
    logic [IW-1:0]     reg_wr_addr;
    logic [DATA_W-1:0] reg_wr_data;
    logic              pc_wr;

    modport master (
        output start, is_store, base_addr, reg_mask,
        output mem_rd_data, reg_rd_data,
        input  stall, busy, done,
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        input  reg_rd_addr, reg_wr_en, reg_wr_addr, reg_wr_data, pc_wr
    );

    modport slave (
        input  start, is_store, base_addr, reg_mask,
        input  mem_rd_data, reg_rd_data,
        output stall, busy, done,
        output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        output reg_rd_addr, reg_wr_en, reg_wr_addr, reg_wr_data, pc_wr
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: walks the register mask one register per cycle,
// drives data memory and register file, and stalls the front end.
module lmsm_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREGS  = 8
) (
    input logic               clk,
    input logic               rst,
    lmsm_sequencer_if.slave   bus
);
    localparam int IW = $clog2(NREGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [NREGS-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              store_q, store_d;
    logic              wb_v_q, wb_v_d;
    logic [IW-1:0]     wb_idx_q, wb_idx_d;
    logic              armed_q;

    logic [IW-1:0]     sel;
    logic [NREGS-1:0]  sel_bit;
    logic              last;
    logic              active;
    logic              in_done;
    logic              accept;

    // Highest set bit of rem is the lowest register index (R0 = MSB).
    always_comb begin
        sel     = '0;
        sel_bit = '0;
        for (int j = 0; j < NREGS; j++) begin
            if (rem_q[j]) begin
                sel          = IW'(NREGS - 1 - j);
                sel_bit      = '0;
                sel_bit[j]   = 1'b1;
            end
        end
    end

    assign last    = (rem_q & (rem_q - 1'b1)) == '0;
    assign active  = (state_q == S_ACTIVE);
    assign in_done = (state_q == S_DONE);
    // armed_q keeps the first cycle after reset release quiet.
    assign accept  = armed_q && bus.start && (state_q == S_IDLE);

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        base_d   = base_q;
        store_d  = store_q;
        wb_v_d   = 1'b0;
        wb_idx_d = wb_idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    store_d = bus.is_store;
                    base_d  = bus.base_addr;
                    rem_d   = bus.reg_mask;
                    state_d = (|bus.reg_mask) ? S_ACTIVE : S_DONE;
                end
            end
            S_ACTIVE: begin
                rem_d = rem_q & ~sel_bit;
                if (!store_q) begin
                    wb_v_d   = 1'b1;
                    wb_idx_d = sel;
                end
                if (last) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            base_q   <= '0;
            store_q  <= 1'b0;
            wb_v_q   <= 1'b0;
            wb_idx_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            base_q   <= base_d;
            store_q  <= store_d;
            wb_v_q   <= wb_v_d;
            wb_idx_q <= wb_idx_d;
            armed_q  <= 1'b1;
        end
    end

    assign bus.busy        = active;
    assign bus.done        = in_done;
    assign bus.stall       = accept | active | in_done;
    assign bus.mem_addr    = active ? base_q + ADDR_W'(sel) : '0;
    assign bus.mem_rd_en   = active & ~store_q;
    assign bus.mem_wr_en   = active & store_q;
    assign bus.reg_rd_addr = (active & store_q) ? sel : '0;
    assign bus.mem_wr_data = (active & store_q) ? bus.reg_rd_data : '0;

    // Write-back runs off its own flop so the last LM write lands in DONE.
    assign bus.reg_wr_en   = wb_v_q;
    assign bus.reg_wr_addr = wb_v_q ? wb_idx_q : '0;
    assign bus.reg_wr_data = wb_v_q ? bus.mem_rd_data : '0;
    assign bus.pc_wr       = wb_v_q && (wb_idx_q == '0);
endmodule

// File: tb/tb_lmsm_sequencer.sv
// Randomized bench for lmsm_sequencer with a transaction-level reference
// model plus memory and register-file environment models.
module tb_lmsm_sequencer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lmsm_sequencer_if #(.DATA_W(16), .ADDR_W(16), .NREGS(8)) bus ();

    lmsm_sequencer #(.DATA_W(16), .ADDR_W(16), .NREGS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        stall, busy, done;
        logic [15:0] addr;
        logic        rd, wr;
        logic [15:0] wdata;
        logic [2:0]  rra;
        logic        rwe;
        logic [2:0]  rwa;
        logic [15:0] rwd;
        logic        pc;
    } exp_t;

    // Environment storage (seen by the DUT) and model storage.
    logic [15:0] mem  [0:65535];
    logic [15:0] mmem [0:65535];
    logic [15:0] rf   [0:7];
    logic [15:0] mrf  [0:7];

    assign bus.reg_rd_data = rf[bus.reg_rd_addr];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = -1;
    int pc_seen = 0;
    logic [15:0] pend;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
        checks++;
        if (act !== exv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exv);
        end
    endtask

    function automatic exp_t zexp();
        exp_t e;
        e.stall = 0; e.busy = 0; e.done = 0; e.addr = 0;
        e.rd = 0; e.wr = 0; e.wdata = 0; e.rra = 0;
        e.rwe = 0; e.rwa = 0; e.rwd = 0; e.pc = 0;
        return e;
    endfunction

    // One clock cycle: compare at negedge, apply DUT-side effects to the
    // environment, then advance to just after the next rising edge.
    task automatic step(input exp_t e);
        @(negedge clk);
        chk("stall",       32'(bus.stall),       32'(e.stall));
        chk("busy",        32'(bus.busy),        32'(e.busy));
        chk("done",        32'(bus.done),        32'(e.done));
        chk("mem_addr",    32'(bus.mem_addr),    32'(e.addr));
        chk("mem_rd_en",   32'(bus.mem_rd_en),   32'(e.rd));
        chk("mem_wr_en",   32'(bus.mem_wr_en),   32'(e.wr));
        chk("mem_wr_data", 32'(bus.mem_wr_data), 32'(e.wdata));
        chk("reg_rd_addr", 32'(bus.reg_rd_addr), 32'(e.rra));
        chk("reg_wr_en",   32'(bus.reg_wr_en),   32'(e.rwe));
        chk("reg_wr_addr", 32'(bus.reg_wr_addr), 32'(e.rwa));
        chk("reg_wr_data", 32'(bus.reg_wr_data), 32'(e.rwd));
        chk("pc_wr",       32'(bus.pc_wr),       32'(e.pc));
        pend = 16'($urandom);
        if (bus.mem_wr_en) mem[bus.mem_addr] = bus.mem_wr_data;
        if (bus.reg_wr_en) rf[bus.reg_wr_addr] = bus.reg_wr_data;
        if (bus.mem_rd_en) pend = mem[bus.mem_addr];
        if (bus.done) done_cyc = cyc;
        if (bus.pc_wr) pc_seen++;
        @(posedge clk);
        #1;
        bus.mem_rd_data = pend;
        cyc++;
    endtask

    task automatic junk_inputs();
        bus.start     = 1'($urandom);
        bus.is_store  = 1'($urandom);
        bus.base_addr = 16'($urandom);
        bus.reg_mask  = 8'($urandom);
    endtask

    task automatic set_mem(input logic [15:0] a, input logic [15:0] d);
        mem[a]  = d;
        mmem[a] = d;
    endtask

    task automatic set_reg(input int i, input logic [15:0] d);
        rf[i]  = d;
        mrf[i] = d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            junk_inputs();
            bus.start = 1'b0;
            step(zexp());
        end
    endtask

    // rst_at: cycle (relative to start) in which reset is pulsed, 0 = none.
    task automatic run_op(input logic st, input logic [15:0] b0,
                          input logic [7:0] m, input int rst_at);
        int idx[$];
        int n;
        exp_t e;
        logic [15:0] a;
        idx = {};
        for (int i = 0; i < 8; i++) if (m[7-i]) idx.push_back(i);
        n = idx.size();
        start_cyc     = cyc;
        bus.start     = 1'b1;
        bus.is_store  = st;
        bus.base_addr = b0;
        bus.reg_mask  = m;
        e = zexp();
        e.stall = 1;
        step(e);
        for (int c = 1; c <= n + 1; c++) begin
            junk_inputs();
            if (c == rst_at) begin
                rst = 1'b1;
                bus.start = 1'b1;
                step(zexp());
                step(zexp());
                rst = 1'b0;
                bus.start = 1'b0;
                step(zexp());
                return;
            end
            e = zexp();
            e.stall = 1;
            if (c <= n) begin
                a = b0 + 16'(idx[c-1]);
                e.busy = 1;
                e.addr = a;
                if (st) begin
                    e.wr    = 1;
                    e.rra   = 3'(idx[c-1]);
                    e.wdata = mrf[idx[c-1]];
                    mmem[a] = mrf[idx[c-1]];
                end else begin
                    e.rd = 1;
                end
            end else begin
                e.done = 1;
            end
            if (!st && c >= 2) begin
                a     = b0 + 16'(idx[c-2]);
                e.rwe = 1;
                e.rwa = 3'(idx[c-2]);
                e.rwd = mmem[a];
                e.pc  = (idx[c-2] == 0);
                mrf[idx[c-2]] = mmem[a];
            end
            step(e);
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int p0;
        int nrst;
        for (int a = 0; a < 65536; a++) set_mem(16'(a), 16'($urandom));
        for (int i = 0; i < 8; i++) set_reg(i, 16'($urandom));
        bus.mem_rd_data = '0;
        rst = 1'b1;
        junk_inputs();
        bus.start = 1'b1;
        step(zexp());
        step(zexp());
        rst = 1'b0;
        bus.start = 1'b0;
        step(zexp());
        idle(1);

        // LM sparse mask
        set_mem(16'h0101, 16'h1111);
        set_mem(16'h0103, 16'h3333);
        run_op(1'b0, 16'h0100, 8'b0101_0000, 0);
        chk("s1_done_lat", 32'(done_cyc - start_cyc), 32'd3);
        chk("s1_r1", 32'(rf[1]), 32'h1111);
        chk("s1_r3", 32'(rf[3]), 32'h3333);
        idle(1);

        // SM full mask
        for (int i = 0; i < 8; i++) set_reg(i, 16'hA000 + 16'(i));
        run_op(1'b1, 16'h0010, 8'hFF, 0);
        chk("s2_done_lat", 32'(done_cyc - start_cyc), 32'd9);
        chk("s2_mem10", 32'(mem[16'h0010]), 32'hA000);
        chk("s2_mem17", 32'(mem[16'h0017]), 32'hA007);
        idle(2);

        // empty mask
        run_op(1'b0, 16'h4000, 8'h00, 0);
        chk("s3_done_lat", 32'(done_cyc - start_cyc), 32'd1);

        // SM address wrap
        set_reg(6, 16'h6666);
        set_reg(7, 16'h7777);
        run_op(1'b1, 16'hFFFE, 8'h03, 0);
        chk("s4_done_lat", 32'(done_cyc - start_cyc), 32'd3);
        chk("s4_mem4", 32'(mem[16'h0004]), 32'h6666);
        chk("s4_mem5", 32'(mem[16'h0005]), 32'h7777);
        idle(1);

        // LM into R0 (PC)
        set_mem(16'h2000, 16'h0040);
        p0 = pc_seen;
        run_op(1'b0, 16'h2000, 8'h80, 0);
        chk("s5_r0", 32'(rf[0]), 32'h0040);
        chk("s5_pc_wr", 32'(pc_seen - p0), 32'd1);
        idle(1);

        // reset mid SM, then a clean SM
        done_cyc = -1;
        run_op(1'b1, 16'h0010, 8'hFF, 3);
        chk("s6_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
        for (int i = 0; i < 8; i++) set_reg(i, 16'hA000 + 16'(i));
        run_op(1'b1, 16'h0010, 8'hFF, 0);
        chk("s6_done_lat", 32'(done_cyc - start_cyc), 32'd9);

        // random traffic with occasional mid-operation reset
        for (int t = 0; t < 60; t++) begin
            logic [7:0] m;
            int cnt;
            m = 8'($urandom);
            cnt = $countones(m);
            nrst = 0;
            if (cnt > 0 && $urandom_range(0, 7) == 0) nrst = $urandom_range(1, cnt);
            run_op(1'($urandom), 16'($urandom), m, nrst);
            idle($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
